// File: rtl/roic_serial_rx_if.sv
// Link-side bundle for roic_serial_rx: serial clock/data in, decoded words and frame status out.
// The err_clr/err_count pair exists only when ROIC_RX_ERRCNT_EN is defined.
interface roic_serial_rx_if #(
   parameter int WORD_BITS = 10
);
   logic                 ClkIn;
   logic                 DataIn;
   logic [WORD_BITS-1:0] word_data;
   logic [2:0]           word_idx;
   logic                 word_valid;
   logic                 frame_done;
   logic                 frame_err;
   logic                 busy;
`ifdef ROIC_RX_ERRCNT_EN
   logic                 err_clr;
   logic [7:0]           err_count;

   modport master (
      output ClkIn, DataIn, err_clr,
      input  word_data, word_idx, word_valid, frame_done, frame_err, busy, err_count
   );

   modport slave (
      input  ClkIn, DataIn, err_clr,
      output word_data, word_idx, word_valid, frame_done, frame_err, busy, err_count
   );
`else
   modport master (
      output ClkIn, DataIn,
      input  word_data, word_idx, word_valid, frame_done, frame_err, busy
   );

   modport slave (
      input  ClkIn, DataIn,
      output word_data, word_idx, word_valid, frame_done, frame_err, busy
   );
`endif
endinterface

// File: rtl/roic_serial_rx.sv
// Oversampling receiver for the ROIC Sout serial stream: preamble lock, MSB-first word deserialisation, trailer check.
// Optional saturating error counter enabled by defining ROIC_RX_ERRCNT_EN.
module roic_serial_rx #(
   parameter int WORD_BITS    = 10,
   parameter int NUM_WORDS    = 5,
   parameter int PREAMBLE_LEN = 10,
   parameter int TRAILER_LEN  = 10,
   parameter int IDLE_TIMEOUT = 255,
   parameter int SYNC_STAGES  = 2
) (
   input logic             fpga_clock,
   input logic             rst,
   roic_serial_rx_if.slave bus
);

   localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);
   localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
   localparam int BIT_W = $clog2(WORD_BITS + 1);
   localparam int TRL_W = $clog2(TRAILER_LEN + 1);

   localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(IDLE_TIMEOUT);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(IDLE_TIMEOUT - 1);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PREAMBLE_LEN - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_BITS - 1);
   localparam logic [TRL_W-1:0] TRL_LAST  = TRL_W'(TRAILER_LEN - 1);
   localparam logic [2:0]       WORD_LAST = 3'(NUM_WORDS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRE   = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_TRAIL = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic [1:0]             state;
   logic [PRE_W-1:0]       pre_cnt;
   logic [BIT_W-1:0]       bit_cnt;
   logic [2:0]             word_cnt;
   logic [TRL_W-1:0]       trl_cnt;
   logic                   trl_bad;
   logic [TO_W-1:0]        to_cnt;
   logic [WORD_BITS-2:0]   shift_reg;
   logic [WORD_BITS-1:0]   shift_next;
   logic [WORD_BITS-1:0]   word_data_q;
   logic [2:0]             word_idx_q;
   logic                   word_valid_q;
   logic                   frame_done_q;
   logic                   frame_err_q;
   logic                   edge_seen;
   logic                   bit_in;
   logic                   timeout_hit;

   // The data line sees the same synchroniser delay as the clock, so its last stage holds the bit launched with the rise.
   assign edge_seen   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
   assign bit_in      = dat_sync[SYNC_STAGES-1];
   assign shift_next  = {shift_reg, bit_in};
   assign timeout_hit = (state != S_IDLE) && !edge_seen && (to_cnt == TO_LAST);

   always_ff @(posedge fpga_clock or posedge rst) begin
      if (rst) begin
         clk_sync     <= '0;
         dat_sync     <= '0;
         clk_prev     <= 1'b0;
         state        <= S_IDLE;
         pre_cnt      <= '0;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         trl_cnt      <= '0;
         trl_bad      <= 1'b0;
         to_cnt       <= '0;
         shift_reg    <= '0;
         word_data_q  <= '0;
         word_idx_q   <= '0;
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync     <= {clk_sync[SYNC_STAGES-2:0], bus.ClkIn};
         dat_sync     <= {dat_sync[SYNC_STAGES-2:0], bus.DataIn};
         clk_prev     <= clk_sync[SYNC_STAGES-1];
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (state == S_IDLE || edge_seen) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
         end

         // A stalled link abandons the frame; any partially shifted word is simply forgotten.
         if (timeout_hit) begin
            frame_err_q <= 1'b1;
            state       <= S_IDLE;
            to_cnt      <= '0;
            pre_cnt     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            trl_cnt     <= '0;
            trl_bad     <= 1'b0;
         end else if (edge_seen) begin
            case (state)
               S_IDLE: begin
                  if (bit_in) begin
                     pre_cnt <= PRE_W'(1);
                     state   <= S_PRE;
                  end
               end
               S_PRE: begin
                  if (!bit_in) begin
                     pre_cnt <= '0;
                     state   <= S_IDLE;
                  end else if (pre_cnt == PRE_LAST) begin
                     pre_cnt  <= '0;
                     bit_cnt  <= '0;
                     word_cnt <= '0;
                     state    <= S_DATA;
                  end else begin
                     pre_cnt <= pre_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  shift_reg <= shift_next[WORD_BITS-2:0];
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt      <= '0;
                     word_data_q  <= shift_next;
                     word_idx_q   <= word_cnt;
                     word_valid_q <= 1'b1;
                     if (word_cnt == WORD_LAST) begin
                        word_cnt <= '0;
                        trl_cnt  <= '0;
                        trl_bad  <= 1'b0;
                        state    <= S_TRAIL;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  if (trl_cnt == TRL_LAST) begin
                     frame_done_q <= ~(trl_bad | bit_in);
                     frame_err_q  <= trl_bad | bit_in;
                     trl_cnt      <= '0;
                     trl_bad      <= 1'b0;
                     state        <= S_IDLE;
                  end else begin
                     trl_cnt <= trl_cnt + 1'b1;
                     trl_bad <= trl_bad | bit_in;
                  end
               end
            endcase
         end
      end
   end

   assign bus.word_data  = word_data_q;
   assign bus.word_idx   = word_idx_q;
   assign bus.word_valid = word_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = (state != S_IDLE);

`ifdef ROIC_RX_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Clear has priority so a clear landing on an error pulse still reads back as zero.
   always_ff @(posedge fpga_clock or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (bus.err_clr) begin
         err_cnt_q <= '0;
      end else if (frame_err_q && err_cnt_q != 8'hFF) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_roic_serial_rx.sv
// Self-checking bench for roic_serial_rx: randomised frames checked against a bit-stream parsing model.
// Define ROIC_RX_ERRCNT_EN to also exercise the error counter.
module tb_roic_serial_rx;

   localparam int WB      = 10;
   localparam int NW      = 5;
   localparam int PRE     = 10;
   localparam int TL      = 10;
   localparam int IDLE_TO = 120;

   logic fpga_clock = 1'b0;
   logic rst        = 1'b1;
   int   cyc        = 0;
   int   checks     = 0;
   int   fails      = 0;

   bit          tx_bits[$];
   logic [12:0] obs_words[$];
   logic [12:0] exp_words[$];
   int          obs_done, obs_err, exp_done, exp_err, both_cnt, err_cyc, last_rise_cyc;
   logic [WB-1:0] frame_words [NW];

   roic_serial_rx_if #(.WORD_BITS(WB)) bus ();

   roic_serial_rx #(
      .WORD_BITS(WB), .NUM_WORDS(NW), .PREAMBLE_LEN(PRE),
      .TRAILER_LEN(TL), .IDLE_TIMEOUT(IDLE_TO), .SYNC_STAGES(2)
   ) dut (
      .fpga_clock(fpga_clock),
      .rst(rst),
      .bus(bus)
   );

   always #5 fpga_clock = ~fpga_clock;

   always @(posedge fpga_clock) cyc <= cyc + 1;

   // Observed-event log, sampled mid-cycle
   always @(negedge fpga_clock) begin
      if (bus.word_valid) obs_words.push_back({bus.word_idx, bus.word_data});
      if (bus.frame_done) obs_done++;
      if (bus.frame_err) begin
         obs_err++;
         err_cyc = cyc;
      end
      if (bus.frame_done && bus.frame_err) both_cnt++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic clear_log();
      obs_words.delete();
      exp_words.delete();
      obs_done = 0;
      obs_err  = 0;
      exp_done = 0;
      exp_err  = 0;
   endtask

   // Reference: parse the transmitted bit stream by the framing rules
   function automatic void model_flush(input bit timed_out);
      int i, n, run, w;
      logic [WB-1:0] v;
      bit bad;
      i = 0;
      n = tx_bits.size();
      while (i < n) begin
         run = 0;
         while (i < n && run < PRE) begin
            run = tx_bits[i] ? run + 1 : 0;
            i++;
         end
         if (run < PRE) begin
            if (timed_out && run > 0) exp_err++;
            break;
         end
         for (w = 0; w < NW && i + WB <= n; w++) begin
            v = '0;
            for (int b = 0; b < WB; b++) v = (v << 1) | WB'(tx_bits[i + b]);
            exp_words.push_back({3'(w), v});
            i += WB;
         end
         if (w < NW || i + TL > n) begin
            if (timed_out) exp_err++;
            break;
         end
         bad = 1'b0;
         for (int b = 0; b < TL; b++) bad |= tx_bits[i + b];
         i += TL;
         if (bad) exp_err++;
         else exp_done++;
      end
      tx_bits.delete();
   endfunction

   task automatic applyStimulus_bit(input bit b);
      @(negedge fpga_clock);
      bus.DataIn = b;
      bus.ClkIn  = 1'b1;
      tx_bits.push_back(b);
      last_rise_cyc = cyc;
      repeat (2) @(negedge fpga_clock);
      bus.ClkIn = 1'b0;
      @(negedge fpga_clock);
   endtask

   task automatic send_word(input logic [WB-1:0] w);
      for (int b = WB - 1; b >= 0; b--) applyStimulus_bit(w[b]);
   endtask

   task automatic send_ones(input int n);
      for (int k = 0; k < n; k++) applyStimulus_bit(1'b1);
   endtask

   // gap < 0 picks a random inter-word gap
   task automatic send_frame(input int gap, input logic [TL-1:0] trl_mask);
      send_ones(PRE);
      for (int w = 0; w < NW; w++) begin
         send_word(frame_words[w]);
         repeat ((gap < 0) ? $urandom_range(0, 40) : gap) @(negedge fpga_clock);
      end
      for (int b = 0; b < TL; b++) applyStimulus_bit(trl_mask[b]);
      repeat (8) @(negedge fpga_clock);
   endtask

   task automatic load_nominal();
      frame_words[0] = 10'h2A5;
      frame_words[1] = 10'h155;
      frame_words[2] = 10'h3FF;
      frame_words[3] = 10'h000;
      frame_words[4] = 10'h000;
   endtask

   task automatic wait_err(input int base, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < IDLE_TO + 40; k++) begin
         @(negedge fpga_clock);
         if (obs_err > base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge fpga_clock);
      checks++;
      if (bus.word_data !== '0) begin fails++; $display("[TB] FAIL reset_word_data: got %h want 0", bus.word_data); end
      checks++;
      if (bus.word_idx !== 3'd0) begin fails++; $display("[TB] FAIL reset_word_idx: got %0d want 0", bus.word_idx); end
      checks++;
      if ({bus.word_valid, bus.frame_done, bus.frame_err, bus.busy} !== 4'b0) begin
         fails++;
         $display("[TB] FAIL reset_strobes: got %b want 0000", {bus.word_valid, bus.frame_done, bus.frame_err, bus.busy});
      end
`ifdef ROIC_RX_ERRCNT_EN
      checks++;
      if (bus.err_count !== 8'd0) begin fails++; $display("[TB] FAIL reset_err_count: got %0d want 0", bus.err_count); end
`endif
      rst = 1'b0;
      repeat (3) @(negedge fpga_clock);
   endtask

   task automatic test_nominal();
      clear_log();
      load_nominal();
      send_frame(35, '0);
      model_flush(1'b0);
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL nominal_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL nominal_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done) begin fails++; $display("[TB] FAIL nominal_done: got %0d want %0d", obs_done, exp_done); end
      checks++;
      if (obs_err !== exp_err) begin fails++; $display("[TB] FAIL nominal_err: got %0d want %0d", obs_err, exp_err); end
   endtask

   task automatic test_broken_preamble();
      clear_log();
      load_nominal();
      send_ones(6);
      applyStimulus_bit(1'b0);
      send_frame(35, '0);
      model_flush(1'b0);
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL brkpre_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL brkpre_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
         fails++;
         $display("[TB] FAIL brkpre_status: got done %0d err %0d want done %0d err %0d", obs_done, obs_err, exp_done, exp_err);
      end
   endtask

   task automatic test_trailer_violation();
      logic [TL-1:0] mask;
      clear_log();
      load_nominal();
      mask = '0;
      mask[4] = 1'b1;
      send_frame(35, mask);
      model_flush(1'b0);
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL trailer_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL trailer_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
         fails++;
         $display("[TB] FAIL trailer_status: got done %0d err %0d want done %0d err %0d", obs_done, obs_err, exp_done, exp_err);
      end
   endtask

   task automatic test_timeout();
      logic [WB-1:0] w2;
      int stop, delay;
      bit ok;
      clear_log();
      send_ones(PRE);
      send_word(WB'($urandom));
      repeat (35) @(negedge fpga_clock);
      send_word(WB'($urandom));
      repeat (35) @(negedge fpga_clock);
      w2 = WB'($urandom);
      for (int b = WB - 1; b > WB - 4; b--) applyStimulus_bit(w2[b]);
      stop = last_rise_cyc;
      repeat (5) @(negedge fpga_clock);
      checks++;
      if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL timeout_busy_before: got %b want 1", bus.busy); end
      wait_err(0, ok);
      checks++;
      if (!ok) begin fails++; $display("[TB] FAIL timeout_fired: got no frame_err want frame_err"); end
      repeat (3) @(negedge fpga_clock);
      model_flush(1'b1);
      delay = err_cyc - stop;
      checks++;
      if (delay < IDLE_TO || delay > IDLE_TO + 6) begin fails++; $display("[TB] FAIL timeout_latency: got %0d cycles want %0d..%0d", delay, IDLE_TO, IDLE_TO + 6); end
      checks++;
      if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy_after: got %b want 0", bus.busy); end
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL timeout_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL timeout_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
         fails++;
         $display("[TB] FAIL timeout_status: got done %0d err %0d want done %0d err %0d", obs_done, obs_err, exp_done, exp_err);
      end
      clear_log();
      load_nominal();
      send_frame(35, '0);
      model_flush(1'b0);
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL timeout_recover_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL timeout_recover_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
         fails++;
         $display("[TB] FAIL timeout_recover_status: got done %0d err %0d want done %0d err %0d", obs_done, obs_err, exp_done, exp_err);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [WB-1:0] w0, w1;
      clear_log();
      w0 = WB'($urandom) | WB'(1);
      w1 = WB'($urandom);
      send_ones(PRE);
      send_word(w0);
      repeat (10) @(negedge fpga_clock);
      for (int b = WB - 1; b >= 5; b--) applyStimulus_bit(w1[b]);
      repeat (2) @(negedge fpga_clock);
      checks++;
      if (bus.busy !== 1'b1 || bus.word_data !== w0) begin
         fails++;
         $display("[TB] FAIL rstmid_before: got busy %b data %h want busy 1 data %h", bus.busy, bus.word_data, w0);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.word_data, bus.word_idx, bus.word_valid, bus.frame_done, bus.frame_err, bus.busy} !== '0) begin
         fails++;
         $display("[TB] FAIL rstmid_async_clear: got data %h idx %0d busy %b want all 0", bus.word_data, bus.word_idx, bus.busy);
      end
      repeat (3) @(negedge fpga_clock);
      rst = 1'b0;
      tx_bits.delete();
      clear_log();
      load_nominal();
      send_frame(35, '0);
      model_flush(1'b0);
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL rstmid_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL rstmid_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
         fails++;
         $display("[TB] FAIL rstmid_status: got done %0d err %0d want done %0d err %0d", obs_done, obs_err, exp_done, exp_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [TL-1:0] mask;
      clear_log();
      both_cnt = 0;
      for (int f = 0; f < 6; f++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            send_ones($urandom_range(0, PRE - 1));
            applyStimulus_bit(1'b0);
         end
         for (int w = 0; w < NW; w++) frame_words[w] = WB'($urandom);
         mask = '0;
         if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, TL - 1)] = 1'b1;
         send_frame(-1, mask);
      end
      model_flush(1'b0);
      checks++;
      if (obs_words.size() != exp_words.size()) begin fails++; $display("[TB] FAIL b2b_count: got %0d words want %0d", obs_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
         checks++;
         if (obs_words[k] !== exp_words[k]) begin fails++; $display("[TB] FAIL b2b_word%0d: got %h want %h", k, obs_words[k], exp_words[k]); end
      end
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
         fails++;
         $display("[TB] FAIL b2b_status: got done %0d err %0d want done %0d err %0d", obs_done, obs_err, exp_done, exp_err);
      end
      checks++;
      if (both_cnt !== 0) begin fails++; $display("[TB] FAIL b2b_done_err_overlap: got %0d cycles want 0", both_cnt); end
   endtask

`ifdef ROIC_RX_ERRCNT_EN
   task automatic test_err_count();
      bit ok;
      int issued, expired;
      logic [7:0] exp_cnt;
      @(negedge fpga_clock);
      bus.err_clr = 1'b1;
      @(negedge fpga_clock);
      bus.err_clr = 1'b0;
      @(negedge fpga_clock);
      checks++;
      if (bus.err_count !== 8'd0) begin fails++; $display("[TB] FAIL errcnt_initial_clear: got %0d want 0", bus.err_count); end
      clear_log();
      issued  = 0;
      expired = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus_bit(1'b1);
         wait_err(obs_err, ok);
         issued++;
         if (!ok) expired++;
      end
      repeat (3) @(negedge fpga_clock);
      tx_bits.delete();
      exp_cnt = 8'(issued);
      checks++;
      if (bus.err_count !== exp_cnt || expired != 0) begin
         fails++;
         $display("[TB] FAIL errcnt_three: got %0d (expired waits %0d) want %0d", bus.err_count, expired, exp_cnt);
      end
      @(negedge fpga_clock);
      bus.err_clr = 1'b1;
      @(negedge fpga_clock);
      bus.err_clr = 1'b0;
      @(negedge fpga_clock);
      checks++;
      if (bus.err_count !== 8'd0) begin fails++; $display("[TB] FAIL errcnt_clear: got %0d want 0", bus.err_count); end
      issued = 0;
      for (int k = 0; k < 300; k++) begin
         applyStimulus_bit(1'b1);
         wait_err(obs_err, ok);
         issued++;
         if (!ok) expired++;
      end
      repeat (3) @(negedge fpga_clock);
      tx_bits.delete();
      exp_cnt = (issued > 255) ? 8'd255 : 8'(issued);
      checks++;
      if (expired != 0) begin fails++; $display("[TB] FAIL errcnt_waits: got %0d expired waits want 0", expired); end
      checks++;
      if (bus.err_count !== exp_cnt) begin fails++; $display("[TB] FAIL errcnt_saturate: got %0d want %0d", bus.err_count, exp_cnt); end
   endtask
`endif

   initial begin
      bus.ClkIn  = 1'b0;
      bus.DataIn = 1'b0;
`ifdef ROIC_RX_ERRCNT_EN
      bus.err_clr = 1'b0;
`endif
      test_reset();
      test_nominal();
      test_broken_preamble();
      test_trailer_violation();
      test_timeout();
      test_reset_mid_word();
      test_back_to_back();
`ifdef ROIC_RX_ERRCNT_EN
      test_err_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/roic_serial_rx.md
Name: roic_serial_rx

Overview:
- Receiver for the two-wire readout stream (serial clock plus serial data) that the ROIC sequencer drives on Sout1/Sout2.
- Oversamples both lines in the fpga_clock domain and locks onto the frame preamble.
- Deserialises the ADC words MSB-first and presents each word with an index and a one-cycle valid strobe.
- Sits on the capture FPGA or test harness at the far end of the readout link, feeding a frame buffer or host interface.

Parameters:
- WORD_BITS, 10, bits per ADC word.
- NUM_WORDS, 5, words per frame (one per readout phase).
- PREAMBLE_LEN, 10, consecutive 1-bits that open a frame.
- TRAILER_LEN, 10, 0-bits that close a frame.
- IDLE_TIMEOUT, 255, fpga_clock cycles without a ClkIn rising edge before an in-frame abort; must exceed the inter-word gap (about 40 cycles).
- SYNC_STAGES, 2, synchroniser flops on ClkIn and DataIn; minimum 2.

Ports:
- fpga_clock  in  1  receiver clock; at least 2x the ClkIn toggle rate.
- rst  in  1  asynchronous, active-high reset.
- ClkIn  in  1  serial clock from the link; asynchronous to fpga_clock.
- DataIn  in  1  serial data from the link; changes in the same source cycle as ClkIn.
- word_data  out  WORD_BITS  last completed word, MSB is the first bit received.
- word_idx  out  3  index of word_data within the frame, 0..NUM_WORDS-1.
- word_valid  out  1  1-cycle strobe; word_data and word_idx are valid in that cycle.
- frame_done  out  1  1-cycle strobe at the end of a good trailer.
- frame_err  out  1  1-cycle strobe on trailer violation or timeout.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Synchronisers are loaded with 0; bit, word and timeout counters are cleared.
  - Asserting rst mid-frame discards the partial word without a strobe.
- Synchronisation and edge detect:
  - ClkIn and DataIn each pass through SYNC_STAGES flops.
  - A rising edge is a 0 in the last stage followed by a 1 in the last stage.
  - The sampled data bit is the DataIn last-stage value in the same cycle the edge is detected. Both lines see equal delay, so the bit is the one launched together with the ClkIn rise.
  - Falling edges are ignored.
- IDLE: a rising edge with bit=1 loads the preamble count with 1 and moves to PREAMBLE. Edges with bit=0 are ignored.
- PREAMBLE:
  - Each edge with bit=1 increments the count.
  - An edge with bit=0 clears the count and returns to IDLE, with no error.
  - When the count reaches PREAMBLE_LEN, move to DATA with the bit count and word index at 0.
- DATA:
  - Each edge shifts the bit into the shift register from the LSB side (MSB-first).
  - On the WORD_BITS-th bit, the next cycle drives word_data with the shift value, word_idx with the index, and word_valid=1. Latency is 1 fpga_clock cycle from the final edge detect.
  - The index then increments. After word NUM_WORDS-1, move to TRAILER.
  - Gaps without edges between words are legal.
- TRAILER:
  - Count TRAILER_LEN edges, recording whether any bit=1 was seen.
  - At the last edge, pulse frame_done if all bits were 0, else pulse frame_err. Either way return to IDLE.
- Timeout:
  - In PREAMBLE, DATA and TRAILER, a counter clears on every rising edge and increments otherwise.
  - Reaching IDLE_TIMEOUT pulses frame_err, drops the partial word and returns to IDLE.
  - The counter saturates and never wraps.
- Output holding: word_data and word_idx hold between strobes. frame_done and frame_err are never high in the same cycle.
- Simultaneous timeout and edge: the edge wins and the counter clears.
- Widths: the index counter is 3 bits, so NUM_WORDS must be 8 or less. The timeout counter is ceil(log2(IDLE_TIMEOUT+1)) bits.

Optional Feature:
- Macro: ROIC_RX_ERRCNT_EN.
- When defined:
  - Adds output err_count (8 bits), reset to 0.
  - err_count increments on each frame_err pulse and saturates at 255.
  - Adds input err_clr (1 bit), which synchronously zeroes err_count. If err_clr and frame_err coincide, the counter reads 0.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Nominal frame: 10 ones, then words 0x2A5, 0x155, 0x3FF, 0x000, 0x000 with 35-cycle gaps, then 10 zeros. Expect 5 word_valid strobes with idx 0..4 and those values, then a single frame_done.
- Broken preamble: 6 ones, a 0, then a full nominal frame. Expect no error, and the frame decodes correctly from the second preamble.
- Trailer violation: nominal frame with trailer bit 4 = 1. Expect all 5 words, frame_err=1 and frame_done=0.
- Timeout: stop ClkIn after 3 bits of word 2. After IDLE_TIMEOUT cycles expect frame_err, busy=0, and no word_valid for idx 2. The next nominal frame decodes correctly.
- Reset mid-word: assert rst during word 1 bit 5. Expect all outputs 0 immediately, asynchronously. After release, a nominal frame gives idx starting at 0.
- With ROIC_RX_ERRCNT_EN: 3 timeout frames give err_count=3. Pulse err_clr and err_count becomes 0. Force 300 errors and err_count holds at 255.
